// File: rtl/instr_slot_router.sv
// instr_slot_router: stripes host and maintenance instructions
// round-robin over per-DFI-slot FWFT queues, padded per sequence.
module instr_slot_router #(
  parameter int N_SLOTS = 2,
  parameter int DEPTH = 16,
  parameter int INSTR_WIDTH = 32,
  parameter logic [3:0] END_OPCODE = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           app_en,
  input  logic [INSTR_WIDTH-1:0]         app_instr,
  output logic                           app_ack,
  input  logic                           maint_en,
  input  logic [INSTR_WIDTH-1:0]         maint_instr,
  output logic                           maint_ack,
  input  logic                           dispatcher_busy,
  output logic                           process_iseq,
  input  logic [N_SLOTS-1:0]             slot_rd_en,
  output logic [N_SLOTS*INSTR_WIDTH-1:0] slot_dout,
  output logic [N_SLOTS-1:0]             slot_empty,
  output logic                           iq_full,
  output logic [INSTR_WIDTH-1:0]         issued_instr,
  output logic                           is_issued_app,
  output logic                           is_issued_mnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {
    ACCEPT,
    PAD,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cursor;
  logic [CW-1:0]          cursor_nxt;
  logic [CW-1:0]          cursor_inc;
  logic                   seq_open;
  logic                   iseq_q;
  logic [N_SLOTS-1:0]     slot_full;
  logic [N_SLOTS-1:0]     wr_en;
  logic                   cur_full;
  logic                   app_end;
  logic                   maint_win;
  logic                   wr_fire;
  logic [INSTR_WIDTH-1:0] wr_data;
  logic                   adv;
  logic                   set_open;
  logic                   clr_open;

  assign app_end = (app_instr[INSTR_WIDTH-1 -: 4] == END_OPCODE);
  assign iq_full = |slot_full;
  assign process_iseq = iseq_q;

  assign cursor_inc = (cursor == CW'(N_SLOTS - 1)) ?
                      '0 : cursor + 1'b1;
  assign cursor_nxt = adv ? cursor_inc : cursor;

  // Full flag of the slot the cursor points at
  always_comb begin
    cur_full = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (cursor == CW'(k)) cur_full = slot_full[k];
    end
  end

  // Steer the single write port to the cursor's queue
  always_comb begin
    wr_en = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (cursor == CW'(k)) wr_en[k] = wr_fire;
    end
  end

  // Per-slot FWFT queues
  for (genvar k = 0; k < N_SLOTS; k++) begin : g_q
    logic [AW:0]            wptr;
    logic [AW:0]            rptr;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic                   rd_fire;
    logic                   wr_ok;

    assign slot_empty[k] = (wptr == rptr);
    assign slot_full[k] = (wptr[AW] != rptr[AW]) &&
                          (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_fire = slot_rd_en[k] & ~slot_empty[k];
    assign wr_ok = wr_en[k] & ~slot_full[k];
    assign slot_dout[k*INSTR_WIDTH +: INSTR_WIDTH] =
      slot_empty[k] ? '0 : mem[rptr[AW-1:0]];

    // Queue pointers; full is judged before any same-cycle pop
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        if (rd_fire) rptr <= rptr + 1'b1;
      end
    end

    // Queue storage
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  // State register and sequence bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ACCEPT;
      cursor   <= '0;
      seq_open <= 1'b0;
      iseq_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cursor <= cursor_nxt;
      iseq_q <= (state_nxt == PAD) && (cursor_nxt == '0);
      unique case (1'b1)
        set_open: seq_open <= 1'b1;
        clr_open: seq_open <= 1'b0;
        default:  seq_open <= seq_open;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCEPT: begin
        if (maint_ack || (app_ack && app_end))
          state_nxt = PAD;
      end
      PAD: begin
        if (cursor == '0) state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dispatcher_busy) state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!dispatcher_busy) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // Handshakes, queue writes and cursor advance
  always_comb begin
    maint_win = 1'b0;
    app_ack   = 1'b0;
    maint_ack = 1'b0;
    wr_fire   = 1'b0;
    wr_data   = NOP_INSTR;
    adv       = 1'b0;
    set_open  = 1'b0;
    clr_open  = 1'b0;
    unique case (state)
      ACCEPT: begin
        if (rst) begin
          maint_win = maint_en & ~seq_open & ~cur_full;
          app_ack   = app_en & ~cur_full & ~maint_win;
          maint_ack = maint_win;
          if (maint_win) begin
            wr_fire = 1'b1;
            wr_data = maint_instr;
            adv     = 1'b1;
          end else if (app_ack && !app_end) begin
            wr_fire  = 1'b1;
            wr_data  = app_instr;
            adv      = 1'b1;
            set_open = 1'b1;
          end
        end
      end
      PAD: begin
        if (cursor == '0) begin
          clr_open = 1'b1;
        end else if (!cur_full) begin
          wr_fire = 1'b1;
          adv     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Last accepted word and its source qualifiers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_instr  <= '0;
      is_issued_app <= 1'b0;
      is_issued_mnt <= 1'b0;
    end else begin
      is_issued_app <= app_ack;
      is_issued_mnt <= maint_ack;
      if (app_ack) issued_instr <= app_instr;
      else if (maint_ack) issued_instr <= maint_instr;
    end
  end

endmodule

// File: tb/tb_instr_slot_router.sv
// tb_instr_slot_router: table, hand-written and randomized
// checks of instr_slot_router in three configurations.
module tb_instr_slot_router;

  localparam int NA = 2;
  localparam logic [31:0] NOP_B = 32'h0BAD_0BAD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u_a: N_SLOTS=2, DEPTH=16
  logic a_app_en, a_maint_en, a_busy;
  logic [31:0] a_app_instr, a_maint_instr, a_iss;
  logic a_app_ack, a_maint_ack, a_proc, a_full, a_ia, a_im;
  logic [1:0] a_rd, a_empty;
  logic [63:0] a_dout;

  // u_b: N_SLOTS=4, DEPTH=4
  logic b_app_en, b_maint_en, b_busy;
  logic [31:0] b_app_instr, b_maint_instr, b_iss;
  logic b_app_ack, b_maint_ack, b_proc, b_full, b_ia, b_im;
  logic [3:0] b_rd, b_empty;
  logic [127:0] b_dout;

  // u_c: N_SLOTS=1, DEPTH=4
  logic c_app_en, c_maint_en, c_busy;
  logic [31:0] c_app_instr, c_maint_instr, c_iss;
  logic c_app_ack, c_maint_ack, c_proc, c_full, c_ia, c_im;
  logic [0:0] c_rd, c_empty;
  logic [31:0] c_dout;

  instr_slot_router #(.N_SLOTS(2), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst),
    .app_en(a_app_en), .app_instr(a_app_instr),
    .app_ack(a_app_ack),
    .maint_en(a_maint_en), .maint_instr(a_maint_instr),
    .maint_ack(a_maint_ack),
    .dispatcher_busy(a_busy), .process_iseq(a_proc),
    .slot_rd_en(a_rd), .slot_dout(a_dout),
    .slot_empty(a_empty), .iq_full(a_full),
    .issued_instr(a_iss),
    .is_issued_app(a_ia), .is_issued_mnt(a_im)
  );

  instr_slot_router #(
    .N_SLOTS(4), .DEPTH(4), .NOP_INSTR(NOP_B)
  ) u_b (
    .clk(clk), .rst(rst),
    .app_en(b_app_en), .app_instr(b_app_instr),
    .app_ack(b_app_ack),
    .maint_en(b_maint_en), .maint_instr(b_maint_instr),
    .maint_ack(b_maint_ack),
    .dispatcher_busy(b_busy), .process_iseq(b_proc),
    .slot_rd_en(b_rd), .slot_dout(b_dout),
    .slot_empty(b_empty), .iq_full(b_full),
    .issued_instr(b_iss),
    .is_issued_app(b_ia), .is_issued_mnt(b_im)
  );

  instr_slot_router #(.N_SLOTS(1), .DEPTH(4)) u_c (
    .clk(clk), .rst(rst),
    .app_en(c_app_en), .app_instr(c_app_instr),
    .app_ack(c_app_ack),
    .maint_en(c_maint_en), .maint_instr(c_maint_instr),
    .maint_ack(c_maint_ack),
    .dispatcher_busy(c_busy), .process_iseq(c_proc),
    .slot_rd_en(c_rd), .slot_dout(c_dout),
    .slot_empty(c_empty), .iq_full(c_full),
    .issued_instr(c_iss),
    .is_issued_app(c_ia), .is_issued_mnt(c_im)
  );

  // fields: app_en maint_en busy | app maint proc ia im
  typedef struct packed {
    logic app_en;
    logic maint_en;
    logic busy;
    logic e_app;
    logic e_mnt;
    logic e_proc;
    logic e_ia;
    logic e_im;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [3:0] op;
    logic [27:0] lo;
    op = 4'($urandom_range(0, 14));
    lo = 28'($urandom);
    return {op, lo};
  endfunction

  // One sequence through u_a, checked against a queue model:
  // words stripe from slot 0 and pad with NOPs to a full group.
  task automatic run_seq(input int n, input bit mnt);
    logic [31:0] exp[$];
    logic [31:0] endw;
    int pads, lat, cnt, groups;
    exp = {};
    if (mnt) begin
      @(negedge clk);
      a_maint_en = 1'b1;
      a_maint_instr = rand_word();
      a_app_en = 1'($urandom_range(0, 1));
      a_app_instr = rand_word();
      #1;
      chk("mnt_ack", 64'(a_maint_ack), 64'd1);
      chk("mnt_app_ack", 64'(a_app_ack), 64'd0);
      exp.push_back(a_maint_instr);
      endw = a_maint_instr;
    end else begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        a_maint_en = 1'b0;
        a_app_en = 1'b1;
        a_app_instr = rand_word();
        #1;
        chk("word_ack", 64'(a_app_ack), 64'd1);
        exp.push_back(a_app_instr);
      end
      @(negedge clk);
      a_maint_en = 1'b0;
      a_app_en = 1'b1;
      a_app_instr = {4'hF, 28'($urandom)};
      #1;
      chk("end_ack", 64'(a_app_ack), 64'd1);
      endw = a_app_instr;
    end
    pads = (NA - (exp.size() % NA)) % NA;
    for (int i = 0; i < pads; i++) exp.push_back(32'h0);
    lat = 0;
    cnt = 0;
    for (int d = 1; d <= pads + 4; d++) begin
      @(negedge clk);
      if (d == 1) begin
        a_app_en = 1'b1;
        a_maint_en = 1'b1;
        a_app_instr = rand_word();
        a_maint_instr = rand_word();
      end
      #1;
      chk("hold_app_ack", 64'(a_app_ack), 64'd0);
      chk("hold_mnt_ack", 64'(a_maint_ack), 64'd0);
      if (d == 1) begin
        chk("issued", 64'(a_iss), 64'(endw));
        chk("is_app", 64'(a_ia), 64'(!mnt));
        chk("is_mnt", 64'(a_im), 64'(mnt));
      end
      if (a_proc) begin
        cnt++;
        if (lat == 0) lat = d;
      end
    end
    chk("iseq_latency", 64'(lat), 64'(1 + pads));
    chk("iseq_count", 64'(cnt), 64'd1);
    groups = exp.size() / NA;
    for (int g = 0; g < groups; g++) begin
      @(negedge clk);
      a_rd = 2'b11;
      #1;
      chk("grp_ack", 64'(a_app_ack | a_maint_ack), 64'd0);
      chk("grp_empty", 64'(a_empty), 64'd0);
      for (int k = 0; k < NA; k++)
        chk("grp_head", 64'(a_dout[k*32 +: 32]),
            64'(exp[g*NA + k]));
    end
    @(negedge clk);
    a_rd = 2'b00;
    #1;
    chk("drained", 64'(a_empty), 64'd3);
    @(negedge clk);
    a_busy = 1'b1;
    #1;
    chk("busy_ack", 64'(a_app_ack | a_maint_ack), 64'd0);
    @(negedge clk);
    a_busy = 1'b0;
    #1;
    chk("idle_ack", 64'(a_app_ack | a_maint_ack), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [5];
    logic [31:0] r;
    {a_app_en, a_maint_en, a_busy, a_rd} = '0;
    {b_app_en, b_maint_en, b_busy, b_rd} = '0;
    {c_app_en, c_maint_en, c_busy, c_rd} = '0;
    a_app_instr = '0; a_maint_instr = '0;
    b_app_instr = 32'h1234_5678;
    b_maint_instr = 32'h7000_0001;
    c_app_instr = '0; c_maint_instr = '0;

    tbl[0]  = 8'b110_01000;
    tbl[1]  = 8'b100_00001;
    tbl[2]  = 8'b100_00000;
    tbl[3]  = 8'b110_00000;
    tbl[4]  = 8'b110_00100;
    tbl[5]  = 8'b110_00000;
    tbl[6]  = 8'b111_00000;
    tbl[7]  = 8'b110_00000;
    tbl[8]  = 8'b100_10000;
    tbl[9]  = 8'b010_00010;
    tbl[10] = 8'b110_10000;
    tbl[11] = 8'b000_00010;

    #2;
    a_app_en = 1'b1;
    #1;
    chk("rst_ack", 64'(a_app_ack), 64'd0);
    chk("rst_empty", 64'(a_empty), 64'd3);
    chk("rst_full", 64'(a_full), 64'd0);
    chk("rst_iseq", 64'(a_proc), 64'd0);
    chk("rst_issued", 64'(a_iss), 64'd0);
    chk("rst_qual", 64'({a_ia, a_im}), 64'd0);
    chk("rst_dout", a_dout, 64'd0);
    a_app_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b_app_en = tbl[i].app_en;
      b_maint_en = tbl[i].maint_en;
      b_busy = tbl[i].busy;
      #1;
      chk($sformatf("tbl%0d_app", i), 64'(b_app_ack),
          64'(tbl[i].e_app));
      chk($sformatf("tbl%0d_mnt", i), 64'(b_maint_ack),
          64'(tbl[i].e_mnt));
      chk($sformatf("tbl%0d_iseq", i), 64'(b_proc),
          64'(tbl[i].e_proc));
      chk($sformatf("tbl%0d_ia", i), 64'(b_ia),
          64'(tbl[i].e_ia));
      chk($sformatf("tbl%0d_im", i), 64'(b_im),
          64'(tbl[i].e_im));
    end
    chk("b_empty", 64'(b_empty), 64'd0);
    chk("b_head0", 64'(b_dout[31:0]), 64'(b_maint_instr));
    for (int k = 1; k < 4; k++)
      chk("b_headpad", 64'(b_dout[k*32 +: 32]), 64'(NOP_B));
    chk("b_issued", 64'(b_iss), 64'(b_app_instr));

    for (int i = 0; i < 5; i++) w[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c_app_en = 1'b1;
      c_app_instr = w[i];
      #1;
      if (i < 4) begin
        chk("c_fill_ack", 64'(c_app_ack), 64'd1);
      end else begin
        chk("c_full", 64'(c_full), 64'd1);
        chk("c_5th_ack", 64'(c_app_ack), 64'd0);
      end
    end
    @(negedge clk);
    c_rd = 1'b1;
    #1;
    chk("c_poppush_ack", 64'(c_app_ack), 64'd0);
    chk("c_head0", 64'(c_dout), 64'(w[0]));
    @(negedge clk);
    c_app_en = 1'b0;
    c_rd = 1'b0;
    #1;
    chk("c_full_clr", 64'(c_full), 64'd0);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      if (j == 1) c_rd = 1'b1;
      #1;
      chk("c_drain", 64'(c_dout), 64'(w[j]));
    end
    @(negedge clk);
    c_rd = 1'b0;
    #1;
    chk("c_level3", 64'(c_empty), 64'd1);

    run_seq(3, 1'b0);
    run_seq(0, 1'b0);
    run_seq(0, 1'b1);
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 3) == 0) run_seq(0, 1'b1);
      else run_seq(int'($urandom_range(0, 6)), 1'b0);
    end

    @(negedge clk);
    a_maint_en = 1'b0;
    a_app_en = 1'b1;
    a_app_instr = rand_word();
    #1;
    chk("r_ack", 64'(a_app_ack), 64'd1);
    @(negedge clk);
    a_app_en = 1'b0;
    #1;
    chk("r_cursor1", 64'(a_empty), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("r_async_empty", 64'(a_empty), 64'd3);
    chk("r_async_issued", 64'(a_iss), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a_app_en = 1'b1;
    r = rand_word();
    a_app_instr = r;
    #1;
    chk("r_post_ack", 64'(a_app_ack), 64'd1);
    @(negedge clk);
    a_app_en = 1'b0;
    #1;
    chk("r_post_slot", 64'(a_empty), 64'd2);
    chk("r_post_head", 64'(a_dout[31:0]), 64'(r));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
